// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logical/arith/compare/branch ops, iterative 1-bit-per-cycle shifts.
// Valid/ready handshake on both sides; one operation in flight at a time.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             branch_taken,
    output logic             illegal
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1011;
    localparam logic [3:0] OP_BLT  = 4'b1100;
    localparam logic [3:0] OP_BLTU = 4'b1101;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] acc, shift_nxt;
    logic [SW-1:0]    cnt, shamt;
    logic             accept, is_shift, long_shift, last_shift;
    logic             lt_s, lt_u;
    logic [WIDTH-1:0] alu_res;
    logic             alu_br, alu_ill;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign accept     = in_valid && in_ready;
    assign shamt      = op_b[SW-1:0];
    assign is_shift   = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
    assign long_shift = is_shift && (shamt != '0);
    assign last_shift = (cnt == SW'(1));
    assign lt_s       = $signed(op_a) < $signed(op_b);
    assign lt_u       = op_a < op_b;

    always_comb begin
        alu_res = '0;
        alu_br  = 1'b0;
        alu_ill = 1'b0;
        case (alu_ctrl)
            OP_ADD:                 alu_res = op_a + op_b;
            OP_SUB:                 alu_res = op_a - op_b;
            OP_SLT:                 alu_res = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU:                alu_res = {{(WIDTH-1){1'b0}}, lt_u};
            OP_XOR:                 alu_res = op_a ^ op_b;
            OP_OR:                  alu_res = op_a | op_b;
            OP_AND:                 alu_res = op_a & op_b;
            OP_SLL, OP_SRL, OP_SRA: alu_res = op_a;  // only reached with shamt == 0
            OP_BEQ: begin
                alu_res = op_a - op_b;
                alu_br  = (op_a == op_b);
            end
            OP_BLT: begin
                alu_res = {{(WIDTH-1){1'b0}}, lt_s};
                alu_br  = lt_s;
            end
            OP_BLTU: begin
                alu_res = {{(WIDTH-1){1'b0}}, lt_u};
                alu_br  = lt_u;
            end
            default:                alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        shift_nxt = {1'b0, acc[WIDTH-1:1]};
        if (op_q == OP_SLL)      shift_nxt = {acc[WIDTH-2:0], 1'b0};
        else if (op_q == OP_SRA) shift_nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = long_shift ? SHIFT : DONE;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= '0;
            acc          <= '0;
            cnt          <= '0;
            result       <= '0;
            zero         <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q <= alu_ctrl;
                    acc  <= op_a;
                    cnt  <= shamt;
                    if (!long_shift) begin
                        result       <= alu_res;
                        zero         <= (alu_res == '0);
                        branch_taken <= alu_br;
                        illegal      <= alu_ill;
                    end
                end
                SHIFT: begin
                    acc <= shift_nxt;
                    cnt <= cnt - SW'(1);
                    if (last_shift) begin
                        result <= shift_nxt;
                        zero   <= (shift_nxt == '0);
                    end
                end
                DONE: if (out_ready) begin
                    // flags read as 0 whenever no result is being offered
                    zero         <= 1'b0;
                    branch_taken <= 1'b0;
                    illegal      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed literal cases plus random traffic checked every cycle
// against a transaction-level model (expected result and completion cycle per accept).
module tb_seq_alu;
    localparam int W = 32;

    logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] op_a, op_b, result;
    logic         zero, branch_taken, illegal;

    int n_cmp = 0;
    int n_bad = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero),
        .branch_taken(branch_taken), .illegal(illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic br, output logic ill,
                                   output int lat);
        int sh;
        sh  = int'(b[4:0]);
        r   = '0;
        br  = 1'b0;
        ill = 1'b0;
        lat = 1;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  begin r = a << sh; lat = sh + 1; end
            4'd3:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd4:  r = (a < b) ? 1 : 0;
            4'd5:  r = a ^ b;
            4'd6:  begin r = a >> sh; lat = sh + 1; end
            4'd7:  begin r = W'($signed(a) >>> sh); lat = sh + 1; end
            4'd8:  r = a | b;
            4'd9:  r = a & b;
            4'd11: begin r = a - b; br = (a == b); end
            4'd12: begin br = ($signed(a) < $signed(b)); r = br ? 1 : 0; end
            4'd13: begin br = (a < b); r = br ? 1 : 0; end
            default: ill = 1'b1;
        endcase
    endfunction

    // Transaction model: busy flag, edge at which the result appears, expected outputs.
    int           cyc = 0;
    bit           m_busy = 0;
    int           m_done = 0;
    logic [W-1:0] m_res;
    logic         m_br, m_ill;

    always @(posedge clk) begin
        int lat;
        cyc++;
        if (!rst_n) m_busy = 0;
        else if (!m_busy) begin
            if (in_valid) begin
                ref_op(alu_ctrl, op_a, op_b, m_res, m_br, m_ill, lat);
                m_done = cyc + lat - 1;
                m_busy = 1;
            end
        end else if (m_done < cyc && out_ready) m_busy = 0;
    end

    always @(negedge clk) begin
        bit ev;
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_result", result, 0);
            chk("rst_flags", {zero, branch_taken, illegal}, 0);
        end else begin
            ev = m_busy && (cyc >= m_done);
            chk("m_out_valid", out_valid, ev);
            chk("m_in_ready", in_ready, !m_busy);
            if (ev) begin
                chk("m_result", result, m_res);
                chk("m_zero", zero, m_res == 0);
                chk("m_branch", branch_taken, m_br);
                chk("m_illegal", illegal, m_ill);
            end else begin
                chk("m_idle_flags", {zero, branch_taken, illegal}, 0);
            end
        end
    end

    task automatic run_op(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold, input logic [W-1:0] er,
                          input logic eb, input logic ei, input int elat);
        int n;
        out_ready = (hold == 0);
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk({nm, "_ready_wait"}, in_ready, 1);
        alu_ctrl = op; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        // junk request while busy must be ignored
        in_valid = (hold > 0); alu_ctrl = 4'd0; op_a = ~a; op_b = ~b;
        n = 1;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk({nm, "_latency"}, n, elat);
        chk({nm, "_result"}, result, er);
        chk({nm, "_zero"}, zero, er == 0);
        chk({nm, "_branch"}, branch_taken, eb);
        chk({nm, "_illegal"}, illegal, ei);
        chk({nm, "_busy"}, in_ready, 0);
        repeat (hold) begin
            @(posedge clk); #1;
            chk({nm, "_hold_result"}, result, er);
            chk({nm, "_hold_valid"}, out_valid, 1);
            chk({nm, "_hold_busy"}, in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_back_idle"}, in_ready, 1);
        chk({nm, "_valid_drop"}, out_valid, 0);
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return W'($urandom_range(0, 40));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctrl = '0; op_a = '0; op_b = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;

        run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 0, 0, 1);
        run_op("sra4", 4'b0111, 32'h8000_0000, 32'hFFFF_FFE4, 0, 32'hF800_0000, 0, 0, 5);
        run_op("srl4", 4'b0110, 32'h8000_0000, 32'hFFFF_FFE4, 0, 32'h0800_0000, 0, 0, 5);
        run_op("sll31", 4'b0010, 32'h1, 32'd31, 0, 32'h8000_0000, 0, 0, 32);
        run_op("sll0", 4'b0010, 32'h1234_5678, 32'h20, 0, 32'h1234_5678, 0, 0, 1);
        run_op("blt", 4'b1100, 32'hFFFF_FFFF, 32'h1, 0, 32'h1, 1, 0, 1);
        run_op("bltu", 4'b1101, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 0, 0, 1);
        run_op("beq", 4'b1011, 32'd5, 32'd5, 0, 32'h0, 1, 0, 1);
        run_op("sub_bp", 4'b0001, 32'd3, 32'd5, 3, 32'hFFFF_FFFE, 0, 0, 1);
        run_op("ill_e", 4'b1110, 32'h55, 32'h66, 0, 32'h0, 0, 1, 1);
        run_op("ill_f", 4'b1111, 32'h55, 32'h66, 0, 32'h0, 0, 1, 1);
        run_op("and", 4'b1001, 32'hF0F0, 32'hFF00, 0, 32'hF000, 0, 0, 1);

        // reset in the middle of a 20-step shift
        alu_ctrl = 4'b0010; op_a = 32'h0000_1234; op_b = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("midshift_valid", out_valid, 0);
        chk("midshift_busy", in_ready, 0);
        rst_n = 1'b0;
        #2;
        chk("abort_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op("xor_after_rst", 4'b0101, 32'hAAAA, 32'hFFFF, 0, 32'h5555, 0, 0, 1);

        for (int i = 0; i < 2500; i++) begin
            @(posedge clk); #1;
            rst_n     = (i != 1200);
            in_valid  = ($urandom_range(0, 9) < 7);
            alu_ctrl  = 4'($urandom_range(0, 15));
            op_a      = rnd_val();
            op_b      = rnd_val();
            out_ready = ($urandom_range(0, 9) < 6);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("drain_idle", in_ready, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
